pito_mvu_launcher: RTL and testbench
====================================

PITO_MVU_LAUNCHER -- requirements
Module: pito_mvu_launcher

Parameters
REQ-001 SHALL have parameter NUM_HARTS, default 8: number of harts, each with its own MVU job slot.
REQ-002 SHALL have parameter NUM_CSRS, default 48: number of 32-bit MVU config words per hart.
REQ-003 SHALL derive HART_W = max(1,clog2(NUM_HARTS)) and ADDR_W = clog2(NUM_CSRS+2); CMD_ADDR = NUM_CSRS; STAT_ADDR = NUM_CSRS+1.

Interface
REQ-004 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have csr_we  input  1  write strobe.
REQ-007 SHALL have csr_re  input  1  read strobe.
REQ-008 SHALL have csr_hart  input  HART_W  target hart.
REQ-009 SHALL have csr_addr  input  ADDR_W  word address within hart.
REQ-010 SHALL have csr_wdata  input  32  write data.
REQ-011 SHALL have csr_rdata  output  32  read data, valid with csr_rvalid.
REQ-012 SHALL have csr_rvalid  output  1  one-cycle read-valid pulse.
REQ-013 SHALL have csr_err  output  1  one-cycle pulse on rejected access.
REQ-014 SHALL have mvu_cfg  output  32*NUM_CSRS*NUM_HARTS  flattened config bank, hart h word a at bits [32*(h*NUM_CSRS+a) +: 32].
REQ-015 SHALL have mvu_start  output  NUM_HARTS  one-cycle launch pulse per hart.
REQ-016 SHALL have mvu_irq_i  input  NUM_HARTS  MVU completion pulse per hart.
REQ-017 SHALL have mvu_done_irq  output  NUM_HARTS  level, high while hart slot in DONE.

Function
REQ-018 SHALL keep per-hart FSM: IDLE(2'd0), BUSY(2'd1), DONE(2'd2); encoding 2'd3 unreachable, recovers to IDLE.
REQ-019 SHALL on write, addr < NUM_CSRS, hart IDLE or DONE: update that config word next edge.
REQ-020 SHALL on write to config word while hart BUSY: drop write, pulse csr_err next cycle.
REQ-021 SHALL on write to CMD_ADDR, hart IDLE: pulse mvu_start[hart] exactly one cycle after the write cycle, enter BUSY same edge, increment 16-bit job counter (wraps 0xFFFF->0x0000).
REQ-022 SHALL on write to CMD_ADDR, hart BUSY or DONE: reject, csr_err pulse, no start, state unchanged.
REQ-023 SHALL on mvu_irq_i[h] in BUSY: enter DONE next edge, raise mvu_done_irq[h].
REQ-024 SHALL ignore mvu_irq_i[h] in IDLE or DONE.
REQ-025 SHALL when irq and rejected command/config write hit the same BUSY hart in the same cycle: take irq (BUSY->DONE), still reject write with csr_err.
REQ-026 SHALL return read data one cycle after csr_re: config word, or status {job_cnt[15:0], 14'b0, state[1:0]} at STAT_ADDR; CMD_ADDR reads 0.
REQ-027 SHALL on status read of a DONE hart: return state 2'd2, then move hart to IDLE, clear mvu_done_irq.
REQ-028 SHALL treat address > STAT_ADDR or csr_hart >= NUM_HARTS as error: csr_err pulse; reads also give csr_rvalid with rdata 0; no state change.
REQ-029 SHALL when csr_we and csr_re both high: perform write only; csr_rvalid stays low.
REQ-030 SHALL operate harts independently; accesses to one hart never alter another.

Reset
REQ-031 SHALL on rst_n low, asynchronously: all FSMs IDLE, all config words 0, job counters 0, mvu_start 0, mvu_done_irq 0, csr_rvalid 0, csr_err 0, csr_rdata 0.
REQ-032 SHALL abort BUSY jobs on reset mid-operation; an irq arriving after reset release is ignored (hart IDLE).

Verification
REQ-033 SHALL cover: write hart2 word5 = 0xDEADBEEF, read back -> rdata 0xDEADBEEF one cycle later, mvu_cfg slice matches.
REQ-034 SHALL cover: CMD write hart0 -> mvu_start[0] single pulse next cycle, status reads 0x00010001; irq -> mvu_done_irq[0]=1; status read -> 0x00010002, then IDLE, irq cleared.
REQ-035 SHALL cover: hart1 BUSY, config write + irq same cycle -> csr_err pulse, word unchanged, hart1 DONE.
REQ-036 SHALL cover: 65536 launch/complete cycles on hart3 -> job counter wraps to 0x0000.
REQ-037 SHALL cover: rst_n low while hart0 BUSY -> all outputs 0; post-reset irq[0] -> no DONE.
REQ-038 SHALL cover: access with addr NUM_CSRS+2 -> csr_err pulse, read data 0, no state change.

Source files
------------

// File: rtl/pito_mvu_launcher.sv
// Per-hart MVU job launcher: a CSR bank of config words per hart, plus a
// command word that fires a start pulse and a status word that acknowledges completion.
module pito_mvu_launcher #(
  parameter int NUM_HARTS = 8,
  parameter int NUM_CSRS  = 48,
  localparam int HART_W   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  localparam int ADDR_W   = $clog2(NUM_CSRS + 2)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            csr_we,
  input  logic                            csr_re,
  input  logic [HART_W-1:0]               csr_hart,
  input  logic [ADDR_W-1:0]               csr_addr,
  input  logic [31:0]                     csr_wdata,
  output logic [31:0]                     csr_rdata,
  output logic                            csr_rvalid,
  output logic                            csr_err,
  output logic [32*NUM_CSRS*NUM_HARTS-1:0] mvu_cfg,
  output logic [NUM_HARTS-1:0]            mvu_start,
  input  logic [NUM_HARTS-1:0]            mvu_irq_i,
  output logic [NUM_HARTS-1:0]            mvu_done_irq,
  output logic [2*NUM_HARTS-1:0]          dbg_state
);

  localparam int CMD_ADDR  = NUM_CSRS;
  localparam int STAT_ADDR = NUM_CSRS + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  state_t      state_q [NUM_HARTS];
  logic [15:0] job_cnt [NUM_HARTS];
  logic [31:0] cfg     [NUM_HARTS][NUM_CSRS];

  // Access protocol: csr_we / csr_re are single-cycle strobes with no
  // backpressure. Every strobe is accepted; reads answer one cycle later with
  // a csr_rvalid pulse, rejected accesses answer with a csr_err pulse in that
  // same following cycle. A write wins when both strobes are high.
  logic hart_ok, addr_ok, acc_ok, is_cfg, is_cmd, is_stat;

  assign hart_ok = int'(csr_hart) < NUM_HARTS;
  assign addr_ok = int'(csr_addr) <= STAT_ADDR;
  assign acc_ok  = hart_ok && addr_ok;
  assign is_cfg  = int'(csr_addr) < NUM_CSRS;
  assign is_cmd  = int'(csr_addr) == CMD_ADDR;
  assign is_stat = int'(csr_addr) == STAT_ADDR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
      csr_err    <= 1'b0;
      mvu_start  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        state_q[h] <= ST_IDLE;
        job_cnt[h] <= '0;
        for (int a = 0; a < NUM_CSRS; a++) cfg[h][a] <= '0;
      end
    end else begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
      csr_err    <= 1'b0;
      mvu_start  <= '0;

      // Completion interrupts first; CSR side effects below override per hart.
      for (int h = 0; h < NUM_HARTS; h++) begin
        case (state_q[h])
          ST_BUSY: if (mvu_irq_i[h]) state_q[h] <= ST_DONE;
          ST_BAD:  state_q[h] <= ST_IDLE;
          default: ;
        endcase
      end

      if (csr_we) begin
        if (!acc_ok) begin
          csr_err <= 1'b1;
        end else if (is_cfg) begin
          if (state_q[csr_hart] == ST_BUSY) csr_err <= 1'b1;
          else cfg[csr_hart][csr_addr] <= csr_wdata;
        end else if (is_cmd) begin
          if (state_q[csr_hart] == ST_IDLE) begin
            mvu_start[csr_hart] <= 1'b1;
            state_q[csr_hart]   <= ST_BUSY;
            job_cnt[csr_hart]   <= job_cnt[csr_hart] + 16'd1;
          end else begin
            csr_err <= 1'b1;
          end
        end
      end else if (csr_re) begin
        csr_rvalid <= 1'b1;
        if (!acc_ok) begin
          csr_err <= 1'b1;
        end else if (is_cfg) begin
          csr_rdata <= cfg[csr_hart][csr_addr];
        end else if (is_stat) begin
          csr_rdata <= {job_cnt[csr_hart], 14'b0, state_q[csr_hart]};
          // Reading status of a finished job acknowledges it.
          if (state_q[csr_hart] == ST_DONE) state_q[csr_hart] <= ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    mvu_done_irq = '0;
    dbg_state    = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mvu_done_irq[h]     = (state_q[h] == ST_DONE);
      dbg_state[2*h +: 2] = state_q[h];
    end
  end

  for (genvar gh = 0; gh < NUM_HARTS; gh++) begin : g_hart
    for (genvar ga = 0; ga < NUM_CSRS; ga++) begin : g_word
      assign mvu_cfg[32*(gh*NUM_CSRS+ga) +: 32] = cfg[gh][ga];
    end
  end

endmodule

// File: tb/tb_pito_mvu_launcher.sv
// Directed self-checking bench for pito_mvu_launcher: config R/W, launch/complete
// flow, irq/write collision, error decode, write-over-read priority, async reset, counter wrap.
module tb_pito_mvu_launcher;

  localparam int NUM_HARTS = 8;
  localparam int NUM_CSRS  = 48;
  localparam int HART_W    = 3;
  localparam int ADDR_W    = 6;
  localparam int CMD_ADDR  = 48;
  localparam int STAT_ADDR = 49;

  logic                             clk = 1'b0;
  logic                             rst_n = 1'b0;
  logic                             csr_we = 1'b0;
  logic                             csr_re = 1'b0;
  logic [HART_W-1:0]                csr_hart = '0;
  logic [ADDR_W-1:0]                csr_addr = '0;
  logic [31:0]                      csr_wdata = '0;
  logic [31:0]                      csr_rdata;
  logic                             csr_rvalid;
  logic                             csr_err;
  logic [32*NUM_CSRS*NUM_HARTS-1:0] mvu_cfg;
  logic [NUM_HARTS-1:0]             mvu_start;
  logic [NUM_HARTS-1:0]             mvu_irq_i = '0;
  logic [NUM_HARTS-1:0]             mvu_done_irq;
  logic [2*NUM_HARTS-1:0]           dbg_state;

  int checks   = 0;
  int failures = 0;

  pito_mvu_launcher #(.NUM_HARTS(NUM_HARTS), .NUM_CSRS(NUM_CSRS)) dut (
    .clk(clk), .rst_n(rst_n), .csr_we(csr_we), .csr_re(csr_re),
    .csr_hart(csr_hart), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_err(csr_err),
    .mvu_cfg(mvu_cfg), .mvu_start(mvu_start), .mvu_irq_i(mvu_irq_i),
    .mvu_done_irq(mvu_done_irq), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Advance one edge and land 1ns after it, where registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int h, input int a, input logic [31:0] d);
    csr_we = 1'b1; csr_hart = h[HART_W-1:0]; csr_addr = a[ADDR_W-1:0]; csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask

  task automatic rd(input int h, input int a);
    csr_re = 1'b1; csr_hart = h[HART_W-1:0]; csr_addr = a[ADDR_W-1:0];
    step();
    csr_re = 1'b0;
  endtask

  task automatic pulse_irq(input logic [NUM_HARTS-1:0] m);
    mvu_irq_i = m;
    step();
    mvu_irq_i = '0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (csr_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", csr_rvalid); end
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", csr_rdata); end
    checks++; if (mvu_start !== 8'h00 || mvu_done_irq !== 8'h00) begin failures++; $display("FAIL reset_start_irq got=%h/%h exp=00/00", mvu_start, mvu_done_irq); end
    checks++; if (mvu_cfg !== '0) begin failures++; $display("FAIL reset_cfg got=nonzero exp=0"); end
    #2 rst_n = 1'b1;
    step();
    rd(0, STAT_ADDR);
    checks++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h0 || csr_err !== 1'b0) begin failures++; $display("FAIL reset_status got=%b/%h/%b exp=1/00000000/0", csr_rvalid, csr_rdata, csr_err); end
  endtask

  task automatic test_cfg_rw();
    wr(2, 5, 32'hDEADBEEF);
    checks++; if (csr_err !== 1'b0) begin failures++; $display("FAIL cfg_wr_err got=%b exp=0", csr_err); end
    rd(2, 5);
    checks++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cfg_rd got=%b/%h exp=1/deadbeef", csr_rvalid, csr_rdata); end
    checks++; if (mvu_cfg[32*(2*NUM_CSRS+5) +: 32] !== 32'hDEADBEEF) begin failures++; $display("FAIL cfg_slice got=%h exp=deadbeef", mvu_cfg[32*(2*NUM_CSRS+5) +: 32]); end
    checks++; if (mvu_cfg[32*(3*NUM_CSRS+5) +: 32] !== 32'h0) begin failures++; $display("FAIL cfg_other_hart got=%h exp=0", mvu_cfg[32*(3*NUM_CSRS+5) +: 32]); end
    step();
    checks++; if (csr_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%b exp=0", csr_rvalid); end
  endtask

  task automatic test_launch();
    wr(0, CMD_ADDR, 32'h0);
    checks++; if (mvu_start !== 8'h01 || csr_err !== 1'b0) begin failures++; $display("FAIL launch_start got=%h/%b exp=01/0", mvu_start, csr_err); end
    step();
    checks++; if (mvu_start !== 8'h00) begin failures++; $display("FAIL launch_single got=%h exp=00", mvu_start); end
    rd(0, STAT_ADDR);
    checks++; if (csr_rdata !== 32'h00010001) begin failures++; $display("FAIL launch_status_busy got=%h exp=00010001", csr_rdata); end
    wr(0, 3, 32'h12345678);
    checks++; if (csr_err !== 1'b1) begin failures++; $display("FAIL busy_cfg_err got=%b exp=1", csr_err); end
    checks++; if (mvu_cfg[32*3 +: 32] !== 32'h0) begin failures++; $display("FAIL busy_cfg_kept got=%h exp=0", mvu_cfg[32*3 +: 32]); end
    wr(0, CMD_ADDR, 32'h0);
    checks++; if (csr_err !== 1'b1 || mvu_start !== 8'h00) begin failures++; $display("FAIL busy_cmd_reject got=%b/%h exp=1/00", csr_err, mvu_start); end
    pulse_irq(8'h01);
    checks++; if (mvu_done_irq !== 8'h01) begin failures++; $display("FAIL done_irq got=%h exp=01", mvu_done_irq); end
    wr(0, CMD_ADDR, 32'h0);
    checks++; if (csr_err !== 1'b1 || mvu_start !== 8'h00) begin failures++; $display("FAIL done_cmd_reject got=%b/%h exp=1/00", csr_err, mvu_start); end
    rd(0, STAT_ADDR);
    checks++; if (csr_rdata !== 32'h00010002) begin failures++; $display("FAIL done_status got=%h exp=00010002", csr_rdata); end
    checks++; if (mvu_done_irq !== 8'h00) begin failures++; $display("FAIL done_ack got=%h exp=00", mvu_done_irq); end
    rd(0, STAT_ADDR);
    checks++; if (csr_rdata !== 32'h00010000) begin failures++; $display("FAIL idle_status got=%h exp=00010000", csr_rdata); end
    pulse_irq(8'h01);
    checks++; if (mvu_done_irq !== 8'h00 || dbg_state[1:0] !== 2'd0) begin failures++; $display("FAIL idle_irq_ignored got=%h/%0d exp=00/0", mvu_done_irq, dbg_state[1:0]); end
  endtask

  task automatic test_irq_collision();
    wr(1, 7, 32'h00000011);
    wr(1, CMD_ADDR, 32'h0);
    checks++; if (mvu_start !== 8'h02) begin failures++; $display("FAIL coll_start got=%h exp=02", mvu_start); end
    csr_we = 1'b1; csr_hart = 3'd1; csr_addr = 6'd7; csr_wdata = 32'h00000022; mvu_irq_i = 8'h02;
    step();
    csr_we = 1'b0; mvu_irq_i = '0;
    checks++; if (csr_err !== 1'b1) begin failures++; $display("FAIL coll_err got=%b exp=1", csr_err); end
    checks++; if (mvu_done_irq !== 8'h02) begin failures++; $display("FAIL coll_done got=%h exp=02", mvu_done_irq); end
    rd(1, 7);
    checks++; if (csr_rdata !== 32'h00000011) begin failures++; $display("FAIL coll_word got=%h exp=00000011", csr_rdata); end
    checks++; if (mvu_cfg[32*(2*NUM_CSRS+5) +: 32] !== 32'hDEADBEEF) begin failures++; $display("FAIL coll_indep got=%h exp=deadbeef", mvu_cfg[32*(2*NUM_CSRS+5) +: 32]); end
    rd(1, STAT_ADDR);
    checks++; if (csr_rdata !== 32'h00010002 || mvu_done_irq !== 8'h00) begin failures++; $display("FAIL coll_status got=%h/%h exp=00010002/00", csr_rdata, mvu_done_irq); end
  endtask

  task automatic test_errors();
    rd(0, STAT_ADDR + 1);
    checks++; if (csr_err !== 1'b1 || csr_rvalid !== 1'b1 || csr_rdata !== 32'h0) begin failures++; $display("FAIL err_rd got=%b/%b/%h exp=1/1/0", csr_err, csr_rvalid, csr_rdata); end
    wr(0, 63, 32'hFFFFFFFF);
    checks++; if (csr_err !== 1'b1 || csr_rvalid !== 1'b0 || mvu_start !== 8'h00) begin failures++; $display("FAIL err_wr got=%b/%b/%h exp=1/0/00", csr_err, csr_rvalid, mvu_start); end
    rd(0, STAT_ADDR);
    checks++; if (csr_rdata !== 32'h00010000 || csr_err !== 1'b0) begin failures++; $display("FAIL err_no_change got=%h/%b exp=00010000/0", csr_rdata, csr_err); end
    rd(0, CMD_ADDR);
    checks++; if (csr_rdata !== 32'h0 || csr_rvalid !== 1'b1 || csr_err !== 1'b0) begin failures++; $display("FAIL cmd_read got=%h/%b/%b exp=0/1/0", csr_rdata, csr_rvalid, csr_err); end
  endtask

  task automatic test_we_re();
    csr_we = 1'b1; csr_re = 1'b1; csr_hart = 3'd4; csr_addr = 6'd0; csr_wdata = 32'hCAFE0001;
    step();
    csr_we = 1'b0; csr_re = 1'b0;
    checks++; if (csr_rvalid !== 1'b0 || csr_err !== 1'b0) begin failures++; $display("FAIL we_re_rvalid got=%b/%b exp=0/0", csr_rvalid, csr_err); end
    checks++; if (mvu_cfg[32*(4*NUM_CSRS) +: 32] !== 32'hCAFE0001) begin failures++; $display("FAIL we_re_write got=%h exp=cafe0001", mvu_cfg[32*(4*NUM_CSRS) +: 32]); end
  endtask

  task automatic test_reset_mid();
    wr(5, CMD_ADDR, 32'h0);
    pulse_irq(8'h20);
    wr(0, 1, 32'h00000005);
    wr(0, CMD_ADDR, 32'h0);
    checks++; if (mvu_start !== 8'h01 || mvu_done_irq !== 8'h20) begin failures++; $display("FAIL pre_reset got=%h/%h exp=01/20", mvu_start, mvu_done_irq); end
    rd(0, STAT_ADDR);
    checks++; if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h00020001) begin failures++; $display("FAIL pre_reset_status got=%b/%h exp=1/00020001", csr_rvalid, csr_rdata); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (csr_rvalid !== 1'b0 || csr_rdata !== 32'h0 || csr_err !== 1'b0) begin failures++; $display("FAIL async_rst_csr got=%b/%h/%b exp=0/0/0", csr_rvalid, csr_rdata, csr_err); end
    checks++; if (mvu_start !== 8'h00 || mvu_done_irq !== 8'h00 || dbg_state !== 16'h0) begin failures++; $display("FAIL async_rst_fsm got=%h/%h/%h exp=00/00/0000", mvu_start, mvu_done_irq, dbg_state); end
    checks++; if (mvu_cfg !== '0) begin failures++; $display("FAIL async_rst_cfg got=nonzero exp=0"); end
    step(); step();
    #2 rst_n = 1'b1;
    step();
    pulse_irq(8'h01);
    checks++; if (mvu_done_irq !== 8'h00) begin failures++; $display("FAIL post_rst_irq got=%h exp=00", mvu_done_irq); end
    rd(0, STAT_ADDR);
    checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL post_rst_status got=%h exp=0", csr_rdata); end
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    for (int i = 0; i < 65535; i++) begin
      wr(3, CMD_ADDR, 32'h0);
      if (mvu_start !== 8'h08) bad++;
      pulse_irq(8'h08);
      rd(3, STAT_ADDR);
      if (csr_rdata[1:0] !== 2'd2) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_loop got=%0d bad_jobs exp=0", bad); end
    rd(3, STAT_ADDR);
    checks++; if (csr_rdata !== 32'hFFFF0000) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff0000", csr_rdata); end
    wr(3, CMD_ADDR, 32'h0);
    rd(3, STAT_ADDR);
    checks++; if (csr_rdata !== 32'h00000001) begin failures++; $display("FAIL wrap_zero got=%h exp=00000001", csr_rdata); end
    pulse_irq(8'h08);
    rd(3, STAT_ADDR);
    checks++; if (csr_rdata !== 32'h00000002) begin failures++; $display("FAIL wrap_done got=%h exp=00000002", csr_rdata); end
  endtask

  initial begin
    test_reset();
    test_cfg_rw();
    test_launch();
    test_irq_collision();
    test_errors();
    test_we_re();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
